// File: rtl/testbasic9_types.sv
// Shared types and defaults for the TestBasic9 upstream source block.
package testbasic9_types;

   localparam int unsigned TB9_SRC_DEPTH = 4;

   typedef logic signed [31:0] tb9_word_t;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      PARTIAL = 2'd1,
      FULL    = 2'd2
   } tb9_src_state_t;

   // Two's-complement add; overflow wraps silently by design.
   function automatic tb9_word_t tb9_add_offset(input tb9_word_t word, input tb9_word_t offset);
      return word + offset;
   endfunction

endpackage

// File: rtl/testbasic9_fifo.sv
// Sample buffer: storage, pointers, occupancy count and full/empty flags.
// Also presents the head word that will be current after this edge.
module testbasic9_fifo
   import testbasic9_types::*;
#(
   parameter int unsigned DEPTH = TB9_SRC_DEPTH
) (
   input  logic      clk,
   input  logic      rst_n,
   input  tb9_word_t wr_data_i,
   input  logic      push_i,
   input  logic      pop_i,
   output logic      full_o,
   output logic      empty_o,
   output tb9_word_t head_next_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   tb9_word_t      mem_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   tb9_src_state_t state_q, state_d;

   assign full_o  = (count_q == DEPTH_C);
   assign empty_o = (count_q == CW'(0));

   // Pointer and count next-state; pointers wrap naturally at a power-of-two depth.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_i) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Next head word: a word written into the slot that becomes the head must bypass memory.
   always_comb begin
      head_next_o = mem_q[rd_ptr_d];
      if (push_i && (rd_ptr_d == wr_ptr_q)) begin
         head_next_o = wr_data_i;
      end else begin
         head_next_o = mem_q[rd_ptr_d];
      end
   end

   // Occupancy state transitions, tracking the count register.
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: begin
            if (push_i && !pop_i) begin
               state_d = PARTIAL;
            end else begin
               state_d = EMPTY;
            end
         end
         PARTIAL: begin
            if (push_i && !pop_i && (count_q == DEPTH_C - CW'(1))) begin
               state_d = FULL;
            end else if (pop_i && !push_i && (count_q == CW'(1))) begin
               state_d = EMPTY;
            end else begin
               state_d = PARTIAL;
            end
         end
         FULL: begin
            if (pop_i) begin
               state_d = PARTIAL;
            end else begin
               state_d = FULL;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // Control registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= EMPTY;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         state_q  <= state_d;
      end
   end

   // Storage is deliberately not reset; the count alone decides validity.
   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

endmodule

// File: rtl/testbasic9_source.sv
// Upstream source for TestBasic9: buffers raw samples, adds a signed offset,
// and counts words delivered to the consumer.
module testbasic9_source
   import testbasic9_types::*;
#(
   parameter int unsigned DEPTH  = TB9_SRC_DEPTH,
   parameter tb9_word_t   OFFSET = 32'sd0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic signed [31:0] s_in,
   input  logic               s_in_sync,
   output logic               s_in_notify,
   output logic signed [31:0] b_out,
   output logic               b_out_notify,
   input  logic               b_out_sync,
   output logic        [31:0] m_out
);

   logic      full_s;
   logic      empty_s;
   logic      push_s;
   logic      pop_s;
   tb9_word_t head_next_s;
   tb9_word_t b_out_q, b_out_d;
   logic [31:0] m_q, m_d;

   // Notifies come only from registered occupancy, never from the partner's sync.
   assign s_in_notify  = !full_s;
   assign b_out_notify = !empty_s;
   assign push_s       = s_in_sync && !full_s;
   assign pop_s        = b_out_sync && !empty_s;

   testbasic9_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst),
      .wr_data_i  (s_in),
      .push_i     (push_s),
      .pop_i      (pop_s),
      .full_o     (full_s),
      .empty_o    (empty_s),
      .head_next_o(head_next_s)
   );

   // Output word and delivered-count next-state.
   always_comb begin
      b_out_d = b_out_q;
      m_d     = m_q;
      if (push_s || pop_s) begin
         b_out_d = tb9_add_offset(head_next_s, OFFSET);
      end else begin
         b_out_d = b_out_q;
      end
      if (pop_s) begin
         m_d = m_q + 32'd1;
      end else begin
         m_d = m_q;
      end
   end

   // Output registers; b_out resets to the bare offset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         b_out_q <= OFFSET;
         m_q     <= 32'd0;
      end else begin
         b_out_q <= b_out_d;
         m_q     <= m_d;
      end
   end

   assign b_out = b_out_q;
   assign m_out = m_q;

endmodule

// File: doc/testbasic9_source.md
# testbasic9_source

Upstream producer for the `TestBasic9` consumer. It accepts raw 32-bit samples on a blocking input and buffers them in a small FIFO. It adds a signed offset to each word and offers the result on a blocking output that connects directly to `TestBasic9`'s `b_in`/`b_in_sync`/`b_in_notify` port. A master output carries the running count of delivered words and drives the consumer's `m_in`.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥ 2.
- `OFFSET`, default 0: signed 32-bit value added to every word on the output path.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset; 0 resets, 1 runs.
- `s_in`  in  32 (integer)  upstream sample.
- `s_in_sync`  in  1  upstream has a valid sample on `s_in`.
- `s_in_notify`  out  1  block can accept a sample this cycle.
- `b_out`  out  32 (integer)  offset-adjusted head word; goes to consumer `b_in`.
- `b_out_notify`  out  1  `b_out` is valid; goes to consumer `b_in_sync`.
- `b_out_sync`  in  1  consumer ready; comes from consumer `b_in_notify`.
- `m_out`  out  32 (integer)  count of words delivered; goes to consumer `m_in`.

## Operation
- Handshake rule, both ports:
  - A transfer occurs in a cycle where notify and sync are both 1 at the rising edge.
  - Neither side may depend combinationally on the other's sync; no combinational path from sync to notify.
- Push: `s_in_sync && s_in_notify` writes `s_in` at `wr_ptr`, advances `wr_ptr`, count +1.
- Pop: `b_out_notify && b_out_sync` advances `rd_ptr`, count −1, `m_out` +1.
- Push and pop in the same cycle: both pointers advance, count unchanged.
- `s_in_notify` = (count != DEPTH), decoded from the count register.
  - When full, no push is taken even if a pop happens that cycle.
  - `s_in_notify` rises the cycle after the pop.
- `b_out_notify` = (count != 0), from the count register.
- `b_out` = mem[`rd_ptr`] + `OFFSET`, 32-bit two's-complement, wraps silently.
  - `b_out` is held stable while `b_out_notify`=1 and no pop occurs.
  - While empty, `b_out` shows the stale slot; the consumer must ignore it.
- Pointers are log2(DEPTH) bits and wrap DEPTH−1 → 0. Count is log2(DEPTH)+1 bits.
- `m_out` wraps 0xFFFFFFFF → 0.
- Internal state: EMPTY (count=0), PARTIAL, FULL (count=DEPTH), derived from count.
  - EMPTY → PARTIAL on push without pop.
  - PARTIAL → FULL when push without pop at count=DEPTH−1.
  - FULL → PARTIAL on pop.
  - PARTIAL → EMPTY when pop without push at count=1.
  - Any other combination stays in the current state.

## Timing
- Reset values (rst=0, asynchronous):
  - `s_in_notify`=1, `b_out_notify`=0, `b_out`=`OFFSET`, `m_out`=0.
  - Pointers=0, count=0. Memory contents are not reset.
- Latency: a word pushed at edge N is offered on `b_out` with `b_out_notify`=1 from edge N (one cycle after `s_in` was presented). No combinational input-to-output bypass.
- Throughput: one push and one pop per cycle in PARTIAL.
- Reset asserted mid-stream: all buffered words are discarded and `m_out` returns to 0 immediately. The first accept after reset deassertion is at the next rising edge.

## Structure
- `testbasic9_types` package holds:
  - `TB9_SRC_DEPTH` (default depth);
  - `tb9_word_t` (32-bit signed);
  - the count-derived state enum `tb9_src_state_t` {EMPTY, PARTIAL, FULL}.
- One sub-module, `testbasic9_fifo`: storage, pointers, count and full/empty.
- The top level adds the offset adder and the `m_out` counter, and drives port naming and reset.

## Test plan
- Reset: hold rst=0 for 3 cycles → `s_in_notify`=1, `b_out_notify`=0, `m_out`=0, `b_out`=`OFFSET`.
- Single word, OFFSET=5: push 10 with `b_out_sync`=1 → next cycle `b_out`=15 and `b_out_notify`=1; the following edge pops it and `m_out`=1.
- Back-pressure: `b_out_sync`=0, push 1,2,3,4 → `s_in_notify`=0 after the 4th push and a 5th sample is not taken. Raising `b_out_sync` then yields 1,2,3,4 in order and `m_out`=4.
- Simultaneous push/pop at count=2 for 8 cycles with consumer always ready → count stays 2, order preserved, `m_out` increments each cycle.
- Wrap: OFFSET=1, push 0x7FFFFFFF → `b_out`=0x80000000 (−2147483648). Force `m_out` to 0xFFFFFFFF, pop → `m_out`=0.
- Mid-operation reset with 3 words buffered → `b_out_notify`=0 and `m_out`=0 asynchronously; after release, the first new word pushed is the first word delivered.
